// File: rtl/spi_reg_bank_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_bank_ctrl_pkg
//  Description : Shared constants, command field positions and FSM state
//                encoding for the SPI command controller / register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_bank_ctrl_pkg;

    // Register address width carried in the command byte
    localparam int ADDR_W       = 7;

    // Address field inside the command byte; the write flag is the word MSB
    localparam int CMD_ADDR_LSB = 0;
    localparam int CMD_ADDR_MSB = 6;

    // Byte shifted out when a read has no valid source byte
    localparam logic [7:0] READ_FILL = 8'h00;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_WAIT  = 3'd1,
        ST_DATA_WAIT = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_TX_LOAD   = 3'd4
    } state_t;

    // Next register address for burst access, wrapping at the top of the bank
    function automatic logic [ADDR_W-1:0] addr_wrap_inc(
        input logic [ADDR_W-1:0] a,
        input int                num_regs
    );
        return (int'(a) == num_regs - 1) ? '0 : a + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_reg_bank_ctrl_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_file
//  Description : Register storage for the SPI register bank. One write port
//                (full register word) and a byte-select read mux returning
//                byte i_rbyte (MSB first) of register i_raddr, or the fill
//                byte when the address or byte index is out of range.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_file
    import spi_reg_bank_ctrl_pkg::*;
#(
    parameter int               SPI_W     = 8,
    parameter int               REG_W     = 16,
    parameter int               NUM_REGS  = 16,
    parameter int               CNT_W     = 2,
    parameter logic [REG_W-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_we,
    input  logic [ADDR_W-1:0]         i_waddr,
    input  logic [REG_W-1:0]          i_wdata,
    input  logic [ADDR_W-1:0]         i_raddr,
    input  logic [CNT_W-1:0]          i_rbyte,
    output logic [SPI_W-1:0]          o_rdata,
    output logic [NUM_REGS*REG_W-1:0] o_reg_q
);

    localparam int NB = REG_W / SPI_W;

    logic [REG_W-1:0] r_q [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // Register gi: load the full word when addressed by the write port
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q[gi] <= RESET_VAL;
                end else if (i_we && (i_waddr == ADDR_W'(gi))) begin
                    r_q[gi] <= i_wdata;
                end
            end

            assign o_reg_q[gi*REG_W +: REG_W] = r_q[gi];
        end
    endgenerate

    // Byte-select read mux; unmatched address/byte falls through to the fill byte
    always_comb begin
        o_rdata = SPI_W'(READ_FILL);
        for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < NB; b++) begin
                if ((i_raddr == ADDR_W'(i)) && (i_rbyte == CNT_W'(b))) begin
                    o_rdata = r_q[i][(NB-1-b)*SPI_W +: SPI_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_bank_ctrl
//  Description : SPI command decoder and register bank controller. Byte 0 of a
//                frame is a command (MSB = write, [6:0] = address), followed
//                by REG_W/SPI_W data bytes MSB first. Writes are assembled and
//                committed to the register file; reads are streamed back one
//                byte per received word.
//  Options     : SPI_REG_AUTOINC_EN - when defined, consecutive words within
//                one chip-select window target incrementing addresses
//                (wrapping NUM_REGS-1 -> 0). Undefined: each word needs a new
//                command byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bank_ctrl
    import spi_reg_bank_ctrl_pkg::*;
#(
    parameter int               SPI_W     = 8,
    parameter int               REG_W     = 16,
    parameter int               NUM_REGS  = 16,
    parameter logic [REG_W-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_cs_n,
    input  logic                      spi_rrdy,
    input  logic [SPI_W-1:0]          spi_rx_data,
    input  logic                      spi_busy,
    output logic                      spi_rx_req,
    output logic                      spi_tx_load_en,
    output logic [SPI_W-1:0]          spi_tx_data,
    output logic [NUM_REGS*REG_W-1:0] reg_q,
    output logic                      wr_stb,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic                      addr_err
);

    localparam int              NB         = REG_W / SPI_W;
    localparam int              CNT_W      = $clog2(NB + 1);
    localparam int              CMD_WR_BIT = SPI_W - 1;
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM_REGS_L);
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_is_wr;
    logic               r_addr_ok;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [SPI_W-1:0]   r_tx_hold;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_addr_err;

    logic               w_rx_req;
    logic               w_load;
    logic               w_we;
    logic               w_latch;
    logic               w_pop;
    logic               w_advance;
    logic               w_last;
    logic [ADDR_W-1:0]  w_cmd_addr;
    logic [ADDR_W-1:0]  w_next_addr;
    logic [REG_W-1:0]   w_wdata;
    logic [SPI_W-1:0]   w_rbyte;

    assign w_last      = (r_byte_cnt == CNT_W'(NB - 1));
    assign w_cmd_addr  = spi_rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign w_next_addr = addr_wrap_inc(r_addr, NUM_REGS);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and strobe decode. A pop that completes a write word still
    // commits even when chip select rises in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_rx_req     = 1'b0;
        w_load       = 1'b0;
        w_we         = 1'b0;
        w_latch      = 1'b0;
        w_pop        = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!spi_cs_n) begin
                    w_state_next = ST_CMD_WAIT;
                end
            end
            ST_CMD_WAIT: begin
                if (spi_rrdy) begin
                    w_rx_req = 1'b1;
                    if (spi_cs_n) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = spi_rx_data[CMD_WR_BIT] ? ST_DATA_WAIT : ST_TX_LOAD;
                    end
                end else if (spi_cs_n) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_TX_LOAD: begin
                if (spi_cs_n) begin
                    w_state_next = ST_IDLE;
                end else if (!spi_busy) begin
                    w_load       = 1'b1;
                    w_state_next = ST_DATA_WAIT;
                end
            end
            ST_DATA_WAIT: begin
                if (spi_rrdy) begin
                    w_rx_req = 1'b1;
                    w_pop    = 1'b1;
                    if (r_is_wr) begin
                        if (w_last) begin
                            w_we         = r_addr_ok;
                            w_state_next = ST_COMMIT;
                        end else if (spi_cs_n) begin
                            w_state_next = ST_IDLE;
                        end
                    end else if (spi_cs_n) begin
                        w_state_next = ST_IDLE;
                    end else if (!w_last) begin
                        w_state_next = ST_TX_LOAD;
                    end else begin
`ifdef SPI_REG_AUTOINC_EN
                        w_advance    = 1'b1;
                        w_state_next = ST_TX_LOAD;
`else
                        w_state_next = ST_CMD_WAIT;
`endif
                    end
                end else if (spi_cs_n) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (spi_cs_n) begin
                    w_state_next = ST_IDLE;
                end else begin
`ifdef SPI_REG_AUTOINC_EN
                    w_advance    = 1'b1;
                    w_state_next = ST_DATA_WAIT;
`else
                    w_state_next = ST_CMD_WAIT;
`endif
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command latch, byte counter, address advance and output holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_is_wr    <= 1'b0;
            r_addr_ok  <= 1'b0;
            r_byte_cnt <= '0;
            r_tx_hold  <= '0;
            r_wr_addr  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            if (w_latch) begin
                r_addr     <= w_cmd_addr;
                r_is_wr    <= spi_rx_data[CMD_WR_BIT];
                r_addr_ok  <= in_range(w_cmd_addr);
                r_byte_cnt <= '0;
                r_addr_err <= !in_range(w_cmd_addr);
            end else if (w_advance) begin
                r_addr     <= w_next_addr;
                r_addr_ok  <= in_range(w_next_addr);
                r_byte_cnt <= '0;
            end else if (w_state_next == ST_IDLE) begin
                r_byte_cnt <= '0;
            end else if (w_pop) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            if (w_load) begin
                r_tx_hold <= w_rbyte;
            end
            if (w_we) begin
                r_wr_addr <= r_addr;
            end
        end
    end

    // Write-word assembly: received bytes shift in MSB first; the final byte
    // bypasses the register so the commit lands on the last pop edge.
    generate
        if (NB > 1) begin : g_asm
            logic [REG_W-SPI_W-1:0] r_asm;

            // Keep the bytes received so far of the word being written
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_asm <= '0;
                end else if (w_pop && r_is_wr) begin
                    r_asm <= w_wdata[REG_W-SPI_W-1:0];
                end
            end

            assign w_wdata = {r_asm, spi_rx_data};
        end else begin : g_no_asm
            assign w_wdata = spi_rx_data;
        end
    endgenerate

    spi_reg_file #(
        .SPI_W     (SPI_W),
        .REG_W     (REG_W),
        .NUM_REGS  (NUM_REGS),
        .CNT_W     (CNT_W),
        .RESET_VAL (RESET_VAL)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (w_wdata),
        .i_raddr (r_addr),
        .i_rbyte (r_byte_cnt),
        .o_rdata (w_rbyte),
        .o_reg_q (reg_q)
    );

    assign spi_rx_req     = w_rx_req;
    assign spi_tx_load_en = w_load;
    assign spi_tx_data    = w_load ? w_rbyte : r_tx_hold;
    assign wr_stb         = (r_state == ST_COMMIT) && r_addr_ok;
    assign wr_addr        = r_wr_addr;
    assign addr_err       = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_reg_bank_ctrl
//  Description : Directed self-checking bench for spi_reg_bank_ctrl
//                (SPI_W=8, REG_W=16, NUM_REGS=16, RESET_VAL=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bank_ctrl;

    localparam int SPI_W    = 8;
    localparam int REG_W    = 16;
    localparam int NUM_REGS = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      spi_cs_n;
    logic                      spi_rrdy;
    logic [SPI_W-1:0]          spi_rx_data;
    logic                      spi_busy;
    logic                      spi_rx_req;
    logic                      spi_tx_load_en;
    logic [SPI_W-1:0]          spi_tx_data;
    logic [NUM_REGS*REG_W-1:0] reg_q;
    logic                      wr_stb;
    logic [6:0]                wr_addr;
    logic                      addr_err;

    spi_reg_bank_ctrl #(
        .SPI_W     (SPI_W),
        .REG_W     (REG_W),
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL ('0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi_cs_n       (spi_cs_n),
        .spi_rrdy       (spi_rrdy),
        .spi_rx_data    (spi_rx_data),
        .spi_busy       (spi_busy),
        .spi_rx_req     (spi_rx_req),
        .spi_tx_load_en (spi_tx_load_en),
        .spi_tx_data    (spi_tx_data),
        .reg_q          (reg_q),
        .wr_stb         (wr_stb),
        .wr_addr        (wr_addr),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    int                        n_chk = 0;
    int                        n_err = 0;
    logic [NUM_REGS*REG_W-1:0] exp_q;

    logic [7:0] loads[$];
    int         stb_cnt = 0;
    int         err_cnt = 0;
    logic [6:0] last_wa = '0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Observe DUT pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (spi_tx_load_en) loads.push_back(spi_tx_data);
            if (wr_stb) begin
                stb_cnt++;
                last_wa = wr_addr;
            end
            if (addr_err) err_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one received word and hold it until the controller pops it
    task automatic push(input logic [7:0] b);
        int k;
        k           = 0;
        spi_rrdy    = 1'b1;
        spi_rx_data = b;
        @(negedge clk);
        while (!spi_rx_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!spi_rx_req) begin
            check("push_timeout", spi_rx_req, 1);
            spi_rrdy = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        spi_rrdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        spi_cs_n    = 1'b1;
        spi_rrdy    = 1'b0;
        spi_rx_data = '0;
        spi_busy    = 1'b0;
        exp_q       = '0;

        // Reset state
        tick(3);
        check("rst_reg_q",   reg_q,          exp_q);
        check("rst_wr_stb",  wr_stb,         0);
        check("rst_strobes", {addr_err, spi_rx_req, spi_tx_load_en}, 0);
        check("rst_tx_data", spi_tx_data,    0);
        check("rst_wr_addr", wr_addr,        0);
        rst_n = 1'b1;
        tick(2);

        // Write 0xBEEF to register 3
        spi_cs_n = 1'b0; tick(1);
        push(8'h83); push(8'hBE); push(8'hEF);
        tick(3); spi_cs_n = 1'b1; tick(2);
        exp_q[3*REG_W +: REG_W] = 16'hBEEF;
        check("wr3_stb_cnt", stb_cnt, 1);
        check("wr3_addr",    last_wa, 3);
        check("wr3_reg_q",   reg_q,   exp_q);
        check("wr3_no_err",  err_cnt, 0);

        // Read register 3, then a third dummy byte
        loads.delete();
        spi_cs_n = 1'b0; tick(1);
        push(8'h03); push(8'h00); push(8'h00); push(8'h00);
        tick(4); spi_cs_n = 1'b1; tick(2);
        check("rd3_byte0", (loads.size() > 0) ? loads[0] : 8'hxx, 8'hBE);
        check("rd3_byte1", (loads.size() > 1) ? loads[1] : 8'hxx, 8'hEF);
        check("rd3_byte2", (loads.size() > 2) ? loads[2] : 8'hxx, 8'h00);
`ifdef SPI_REG_AUTOINC_EN
        check("rd3_nloads", loads.size(), 4);
`else
        check("rd3_nloads", loads.size(), 3);
`endif

        // Aborted write to register 2, then a fresh command decodes cleanly
        spi_cs_n = 1'b0; tick(1);
        push(8'h82); push(8'h12);
        tick(1); spi_cs_n = 1'b1; tick(2);
        check("abort_stb_cnt", stb_cnt, 1);
        check("abort_reg_q",   reg_q,   exp_q);
        spi_cs_n = 1'b0; tick(1);
        push(8'h85); push(8'h12); push(8'h34);
        tick(3); spi_cs_n = 1'b1; tick(2);
        exp_q[5*REG_W +: REG_W] = 16'h1234;
        check("wr5_stb_cnt", stb_cnt, 2);
        check("wr5_addr",    last_wa, 5);
        check("wr5_reg_q",   reg_q,   exp_q);

        // Out-of-range write to 0x40 is dropped with one addr_err pulse
        spi_cs_n = 1'b0; tick(1);
        push(8'hC0); push(8'hAA); push(8'h55);
        tick(3); spi_cs_n = 1'b1; tick(2);
        check("oor_err_cnt", err_cnt, 1);
        check("oor_stb_cnt", stb_cnt, 2);
        check("oor_reg_q",   reg_q,   exp_q);

        // Out-of-range read (0x43 would alias reg 3 if the address were truncated)
        loads.delete();
        spi_cs_n = 1'b0; tick(1);
        push(8'h43); push(8'h00); push(8'h00);
        tick(3); spi_cs_n = 1'b1; tick(2);
        check("oor_rd_byte0", (loads.size() > 0) ? loads[0] : 8'hxx, 8'h00);
        check("oor_rd_byte1", (loads.size() > 1) ? loads[1] : 8'hxx, 8'h00);
        check("oor_rd_err",   err_cnt, 2);

        // TX load held while the core is busy
        loads.delete();
        spi_busy = 1'b1;
        spi_cs_n = 1'b0; tick(1);
        push(8'h05);
        tick(3);
        check("busy_hold", loads.size(), 0);
        spi_busy = 1'b0;
        tick(2);
        check("busy_nloads", loads.size(), 1);
        check("busy_byte0", (loads.size() > 0) ? loads[0] : 8'hxx, 8'h12);
        push(8'h00);
        tick(2);
        check("busy_byte1", (loads.size() > 1) ? loads[1] : 8'hxx, 8'h34);
        spi_cs_n = 1'b1; tick(2);

        // Last write byte arrives together with chip select rising
        spi_cs_n = 1'b0; tick(1);
        push(8'h86); push(8'hCA);
        spi_rrdy    = 1'b1;
        spi_rx_data = 8'hFE;
        spi_cs_n    = 1'b1;
        @(negedge clk);
        check("cs_rise_pop", spi_rx_req, 1);
        tick(1);
        spi_rrdy = 1'b0;
        tick(2);
        exp_q[6*REG_W +: REG_W] = 16'hCAFE;
        check("cs_rise_stb_cnt", stb_cnt, 3);
        check("cs_rise_addr",    last_wa, 6);
        check("cs_rise_reg_q",   reg_q,   exp_q);

`ifdef SPI_REG_AUTOINC_EN
        // Burst write wrapping from the last register to register 0
        spi_cs_n = 1'b0; tick(1);
        push(8'h8F); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick(3); spi_cs_n = 1'b1; tick(2);
        exp_q[15*REG_W +: REG_W] = 16'h1122;
        exp_q[0*REG_W  +: REG_W] = 16'h3344;
        check("burst_stb_cnt", stb_cnt, 5);
        check("burst_err_cnt", err_cnt, 2);
        check("burst_reg_q",   reg_q,   exp_q);
`endif

        // Asynchronous reset in the commit cycle of a write
        spi_cs_n = 1'b0; tick(1);
        push(8'h87); push(8'h99); push(8'h77);
        check("pre_rst_stb", wr_stb, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reg_q",   reg_q,       0);
        check("async_wr_stb",  wr_stb,      0);
        check("async_wr_addr", wr_addr,     0);
        check("async_tx_data", spi_tx_data, 0);
        check("async_strobes", {addr_err, spi_rx_req, spi_tx_load_en}, 0);
        spi_cs_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
